// File: rtl/ex_stage.sv
// Y86 execute stage: ALU, condition codes, jump/cmov condition and the EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier for OPl/mull (icode 6, ifun 4).
//
// Multiplier FSM (EX_MUL_EN only)
//   state    | meaning
//   MUL_IDLE | no multiply in flight; mull presentation raises ex_busy combinationally
//   MUL_RUN  | one add/shift per edge, 32 edges, ex_busy held high
//   MUL_DONE | product valid; next edge writes EX/MEM and CC, then back to idle

module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_icode,
  input  logic [7:0]  ex_ifun,
  input  logic [31:0] ex_valA,
  input  logic [31:0] ex_valB,
  input  logic [31:0] ex_valC,
  input  logic [7:0]  ex_dstE,
  input  logic [7:0]  ex_dstM,
  input  logic        ex_bubble,
  output logic        ex_busy,
  output logic [31:0] fwd_valE,
  output logic [7:0]  fwd_dstE,
  output logic [7:0]  mem_icode,
  output logic [7:0]  mem_ifun,
  output logic [31:0] mem_valE,
  output logic [31:0] mem_valA,
  output logic [7:0]  mem_dstE,
  output logic [7:0]  mem_dstM,
  output logic        mem_cnd,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  localparam logic [7:0] I_NOP    = 8'h1;
  localparam logic [7:0] I_CMOV   = 8'h2;
  localparam logic [7:0] I_IRMOV  = 8'h3;
  localparam logic [7:0] I_RMMOV  = 8'h4;
  localparam logic [7:0] I_MRMOV  = 8'h5;
  localparam logic [7:0] I_OPL    = 8'h6;
  localparam logic [7:0] I_JXX    = 8'h7;
  localparam logic [7:0] I_CALL   = 8'h8;
  localparam logic [7:0] I_RET    = 8'h9;
  localparam logic [7:0] I_PUSH   = 8'hA;
  localparam logic [7:0] I_POP    = 8'hB;
  localparam logic [7:0] REG_NONE = 8'hF;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [7:0]  alu_fn;
  logic [31:0] alu_out;
  logic        alu_of;
  logic        is_opl;
  logic        fn_valid;
  logic        mul_op;
  logic        mul_ok;
  logic [31:0] val_e;
  logic [7:0]  dst_e_eff;
  logic        cnd;
  logic        mem_cnd_nxt;
  logic        cc_we;

  always_comb begin
    alu_a = 32'h0;
    case (ex_icode)
      I_CMOV, I_OPL:           alu_a = ex_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = ex_valC;
      I_CALL, I_PUSH:          alu_a = 32'hFFFF_FFFC;
      I_RET, I_POP:            alu_a = 32'h0000_0004;
      default:                 alu_a = 32'h0;
    endcase
  end

  always_comb begin
    alu_b = 32'h0;
    case (ex_icode)
      I_RMMOV, I_MRMOV, I_OPL, I_CALL, I_RET, I_PUSH, I_POP: alu_b = ex_valB;
      default: alu_b = 32'h0;
    endcase
  end

  assign is_opl   = (ex_icode == I_OPL);
  assign alu_fn   = is_opl ? ex_ifun : 8'h0;
  assign fn_valid = (alu_fn < 8'd4);
  assign mul_op   = is_opl && (ex_ifun == 8'd4);

  always_comb begin
    alu_out = 32'h0;
    alu_of  = 1'b0;
    case (alu_fn)
      8'd0: begin
        alu_out = alu_b + alu_a;
        alu_of  = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      8'd1: begin
        alu_out = alu_b - alu_a;
        alu_of  = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_b[31]);
      end
      8'd2:    alu_out = alu_b & alu_a;
      8'd3:    alu_out = alu_b ^ alu_a;
      default: alu_out = 32'h0;
    endcase
  end

  // Condition uses the CC as it stands before this instruction's update.
  always_comb begin
    cnd = 1'b0;
    case (ex_ifun)
      8'd0:    cnd = 1'b1;
      8'd1:    cnd = (cc_sf ^ cc_of) | cc_zf;
      8'd2:    cnd = cc_sf ^ cc_of;
      8'd3:    cnd = cc_zf;
      8'd4:    cnd = ~cc_zf;
      8'd5:    cnd = ~(cc_sf ^ cc_of);
      8'd6:    cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cnd = 1'b0;
    endcase
  end

  assign mem_cnd_nxt = ((ex_icode == I_CMOV) || (ex_icode == I_JXX)) ? cnd : 1'b1;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

  mul_state_t  mul_state;
  logic [31:0] mul_mcand;
  logic [31:0] mul_mplier;
  logic [31:0] mul_acc;
  logic [4:0]  mul_left;

  assign ex_busy = (mul_state == MUL_RUN) ||
                   ((mul_state == MUL_IDLE) && mul_op && !ex_bubble);
  assign mul_ok  = mul_op && (mul_state == MUL_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state  <= MUL_IDLE;
      mul_mcand  <= 32'h0;
      mul_mplier <= 32'h0;
      mul_acc    <= 32'h0;
      mul_left   <= 5'd0;
    end else begin
      case (mul_state)
        MUL_IDLE: begin
          if (mul_op && !ex_bubble) begin
            mul_mcand  <= alu_b;
            mul_mplier <= alu_a;
            mul_acc    <= 32'h0;
            mul_left   <= 5'd31;
            mul_state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (ex_bubble) begin
            mul_state <= MUL_IDLE;
          end else begin
            mul_acc    <= mul_acc + (mul_mplier[0] ? mul_mcand : 32'h0);
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_left   <= mul_left - 5'd1;
            if (mul_left == 5'd0) mul_state <= MUL_DONE;
          end
        end
        MUL_DONE: mul_state <= MUL_IDLE;
        default:  mul_state <= MUL_IDLE;
      endcase
    end
  end

  assign val_e = mul_ok ? mul_acc : alu_out;
`else
  assign ex_busy = 1'b0;
  assign mul_ok  = 1'b0;
  assign val_e   = alu_out;
`endif

  // Failed cmov and an unsupported mull both suppress the register write.
  assign dst_e_eff = (((ex_icode == I_CMOV) && !cnd) || (mul_op && !mul_ok)) ? REG_NONE : ex_dstE;

  assign fwd_valE = ex_busy ? 32'h0 : val_e;
  assign fwd_dstE = ex_busy ? REG_NONE : dst_e_eff;

  assign cc_we = is_opl && (fn_valid || mul_ok) && !ex_bubble && !ex_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (cc_we) begin
      cc_zf <= (val_e == 32'h0);
      cc_sf <= val_e[31];
      cc_of <= mul_ok ? 1'b0 : alu_of;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ex_bubble || ex_busy) begin
      mem_icode <= I_NOP;
      mem_ifun  <= 8'h0;
      mem_valE  <= 32'h0;
      mem_valA  <= 32'h0;
      mem_dstE  <= REG_NONE;
      mem_dstM  <= REG_NONE;
      mem_cnd   <= 1'b1;
    end else begin
      mem_icode <= ex_icode;
      mem_ifun  <= ex_ifun;
      mem_valE  <= val_e;
      mem_valA  <= ex_valA;
      mem_dstE  <= dst_e_eff;
      mem_dstM  <= ex_dstM;
      mem_cnd   <= mem_cnd_nxt;
    end
  end

endmodule
